// File: rtl/sort_pkg.sv
// Shared definitions for the four-input byte sorter and its upstream feeder.
// Holds the default operand width, the short-group pad value and the byte type.
package sort_pkg;

  localparam int DW_DEF = 8;

  localparam logic [DW_DEF-1:0] PAD_DEF = 8'hFF;

  typedef logic [DW_DEF-1:0] byte_t;

endpackage

// File: rtl/quad_slot_buf.sv
// Four-slot fill buffer: collects bytes into a group and can hold one completed
// group while the output register is occupied.
module quad_slot_buf
  import sort_pkg::*;
#(
  parameter int            DW  = DW_DEF,
  parameter logic [DW-1:0] PAD = PAD_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 wr_last_i,
  input  logic                 hold_i,
  input  logic                 pop_i,
  output logic                 done_o,
  output logic                 full_o,
  output logic [3:0][DW-1:0]   grp_word_o,
  output logic [2:0]           grp_cnt_o
);

  logic [DW-1:0]       slot_q [4];
  logic [1:0]          fcnt_q, fcnt_d;
  logic                full_q, full_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [3:0][DW-1:0]  merged;
  logic [3:0]          slot_we;

  assign done_o = wr_en_i && ((fcnt_q == 2'd3) || wr_last_i);
  assign full_o = full_q;

  // Group as it would look if closed by the byte on wr_data_i this cycle.
  always_comb begin
    merged  = '0;
    slot_we = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(fcnt_q)) begin
        merged[i] = slot_q[i];
      end else if (i == int'(fcnt_q)) begin
        merged[i] = wr_data_i;
      end else begin
        merged[i] = PAD;
      end
      slot_we[i] = wr_en_i &&
                   ((i == int'(fcnt_q)) || (done_o && hold_i && (i > int'(fcnt_q))));
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      grp_word_o[i] = full_q ? slot_q[i] : merged[i];
    end
    grp_cnt_o = full_q ? cnt_q : ({1'b0, fcnt_q} + 3'd1);
  end

  always_comb begin
    fcnt_d = fcnt_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    if (wr_en_i) begin
      fcnt_d = done_o ? 2'd0 : (fcnt_q + 2'd1);
    end
    if (done_o && hold_i) begin
      full_d = 1'b1;
      cnt_d  = {1'b0, fcnt_q} + 3'd1;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= 2'd0;
      full_q <= 1'b0;
      cnt_q  <= 3'd0;
    end else begin
      fcnt_q <= fcnt_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q[gi] <= '0;
      end else if (slot_we[gi]) begin
        slot_q[gi] <= merged[gi];
      end
    end
  end

endmodule

// File: rtl/quad_gather.sv
// Packs a byte stream into four-operand groups for the sorter, double-buffered.
// Define QUAD_GATHER_PAD_EN to allow in_last to close short, PAD-filled groups.
module quad_gather
  import sort_pkg::*;
#(
  parameter int            DW  = DW_DEF,
  parameter logic [DW-1:0] PAD = PAD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  output logic [DW-1:0] a,
  output logic [DW-1:0] b,
  output logic [DW-1:0] c,
  output logic [DW-1:0] d,
  output logic          grp_valid,
  input  logic          grp_ready,
  output logic [2:0]    grp_cnt
);

  logic                out_free;
  logic                accept;
  logic                grp_last;
  logic                buf_done;
  logic                buf_full;
  logic                load;
  logic [3:0][DW-1:0]  buf_word;
  logic [2:0]          buf_cnt;

  logic [3:0][DW-1:0]  grp_q, grp_d;
  logic                grp_valid_q, grp_valid_d;

  assign out_free = !grp_valid_q || grp_ready;
  assign in_ready = !buf_full;
  assign accept   = in_valid && in_ready;
  // A held group and a freshly completed one are mutually exclusive: no accept while full.
  assign load     = (buf_done || buf_full) && out_free;

`ifdef QUAD_GATHER_PAD_EN
  assign grp_last = in_last;
`else
  logic unused_in_last;
  assign grp_last       = 1'b0;
  assign unused_in_last = in_last;
`endif

  quad_slot_buf #(
    .DW  (DW),
    .PAD (PAD)
  ) u_slot_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (accept),
    .wr_data_i  (in_data),
    .wr_last_i  (grp_last),
    .hold_i     (!out_free),
    .pop_i      (buf_full && out_free),
    .done_o     (buf_done),
    .full_o     (buf_full),
    .grp_word_o (buf_word),
    .grp_cnt_o  (buf_cnt)
  );

  always_comb begin
    grp_d       = grp_q;
    grp_valid_d = grp_valid_q;
    if (load) begin
      grp_d       = buf_word;
      grp_valid_d = 1'b1;
    end else if (grp_ready) begin
      grp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q       <= '0;
      grp_valid_q <= 1'b0;
    end else begin
      grp_q       <= grp_d;
      grp_valid_q <= grp_valid_d;
    end
  end

`ifdef QUAD_GATHER_PAD_EN
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = buf_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grp_cnt = cnt_q;
`else
  logic [2:0] unused_buf_cnt;
  assign unused_buf_cnt = buf_cnt;
  assign grp_cnt        = 3'd4;
`endif

  assign a         = grp_q[0];
  assign b         = grp_q[1];
  assign c         = grp_q[2];
  assign d         = grp_q[3];
  assign grp_valid = grp_valid_q;

endmodule

// File: tb/tb_quad_gather.sv
// Scoreboard bench for quad_gather: directed byte sequences push expected groups,
// a monitor compares every group transfer against the queue.
module tb_quad_gather;
  import sort_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  byte_t      in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_last = 1'b0;
  byte_t      a, b, c, d;
  logic       grp_valid;
  logic       grp_ready = 1'b0;
  logic [2:0] grp_cnt;

  int tests = 0;
  int fails = 0;
  int stall_cycles = 0;

  typedef struct packed {
    byte_t      a;
    byte_t      b;
    byte_t      c;
    byte_t      d;
    logic [2:0] cnt;
  } grp_t;

  grp_t sb[$];

`ifdef QUAD_GATHER_PAD_EN
  localparam logic [2:0] RESET_CNT = 3'd0;
`else
  localparam logic [2:0] RESET_CNT = 3'd4;
`endif

  quad_gather dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .grp_valid (grp_valid),
    .grp_ready (grp_ready),
    .grp_cnt   (grp_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic push(input byte_t ea, input byte_t eb, input byte_t ec, input byte_t ed,
                      input logic [2:0] ecnt);
    grp_t e;
    e.a = ea; e.b = eb; e.c = ec; e.d = ed; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input byte_t dv, input logic lv);
    int waitc;
    waitc    = 0;
    in_data  = dv;
    in_last  = lv;
    in_valid = 1'b1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    stall_cycles += waitc;
    if (!in_ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL send_timeout: byte %02h not accepted, in_ready=%0b required 1", dv, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Monitor: a transfer happens on the next rising edge when valid and ready are both high.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && grp_valid && grp_ready) begin
        grp_t e;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_group: got %02h %02h %02h %02h cnt %0d, required none",
                   a, b, c, d, grp_cnt);
        end else begin
          e = sb.pop_front();
          if ({a, b, c, d, grp_cnt} !== e) begin
            fails++;
            $display("[TB] FAIL group: got %02h %02h %02h %02h cnt %0d, required %02h %02h %02h %02h cnt %0d",
                     a, b, c, d, grp_cnt, e.a, e.b, e.c, e.d, e.cnt);
          end else begin
            $display("[TB] group %02h %02h %02h %02h cnt %0d ok", a, b, c, d, grp_cnt);
          end
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_grp_valid", 32'(grp_valid), 32'd0);
    check("reset_operands", {a, b, c, d}, 32'h0);
    check("reset_grp_cnt", 32'(grp_cnt), 32'(RESET_CNT));

    // First group and latency
    grp_ready = 1'b1;
    push(8'd0, 8'd2, 8'd7, 8'd4, 3'd4);
    send(8'd0, 1'b0);
    send(8'd2, 1'b0);
    send(8'd7, 1'b0);
    check("pre_complete_valid", 32'(grp_valid), 32'd0);
    send(8'd4, 1'b0);
    check("latency_valid", 32'(grp_valid), 32'd1);
    check("latency_operands", {a, b, c, d}, 32'h00020704);

    // Sustained stream
    stall_cycles = 0;
    for (int i = 1; i <= 12; i++) begin
      if (i % 4 == 0) push(byte_t'(i - 3), byte_t'(i - 2), byte_t'(i - 1), byte_t'(i), 3'd4);
      send(byte_t'(i), 1'b0);
    end
    check("stream_no_stall", 32'(stall_cycles), 32'd0);
    check("stream_last_group", {a, b, c, d}, 32'h090a0b0c);

    // Stall with both buffers full
    @(negedge clk);
    grp_ready = 1'b0;
    push(8'd1, 8'd2, 8'd3, 8'd4, 3'd4);
    push(8'd5, 8'd6, 8'd7, 8'd8, 3'd4);
    for (int i = 1; i <= 8; i++) send(byte_t'(i), 1'b0);
    check("stall_in_ready_low", 32'(in_ready), 32'd0);
    check("stall_hold_operands", {a, b, c, d}, 32'h01020304);
    in_data  = 8'd9;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_still_blocked", 32'(in_ready), 32'd0);
    check("stall_stable_operands", {a, b, c, d}, 32'h01020304);
    grp_ready = 1'b1;
    @(negedge clk);
    grp_ready = 1'b0;
    check("unstall_in_ready", 32'(in_ready), 32'd1);
    check("unstall_operands", {a, b, c, d}, 32'h05060708);
    check("unstall_valid", 32'(grp_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    push(8'd9, 8'd10, 8'd11, 8'd12, 3'd4);
    send(8'd10, 1'b0);
    send(8'd11, 1'b0);
    send(8'd12, 1'b0);
    check("refill_held", 32'(in_ready), 32'd0);
    grp_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Simultaneous consume and 4th-byte accept
    grp_ready = 1'b0;
    push(8'd20, 8'd21, 8'd22, 8'd23, 3'd4);
    for (int i = 20; i <= 26; i++) send(byte_t'(i), 1'b0);
    push(8'd24, 8'd25, 8'd26, 8'd27, 3'd4);
    grp_ready = 1'b1;
    send(8'd27, 1'b0);
    grp_ready = 1'b0;
    check("swap_valid", 32'(grp_valid), 32'd1);
    check("swap_operands", {a, b, c, d}, 32'h18191a1b);
    check("swap_in_ready", 32'(in_ready), 32'd1);
    grp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset with a held group and a partial group in flight
    grp_ready = 1'b0;
    for (int i = 30; i <= 35; i++) send(byte_t'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", 32'(grp_valid), 32'd0);
    check("midreset_operands", {a, b, c, d}, 32'h0);
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    grp_ready = 1'b1;
    push(8'd9, 8'd9, 8'd9, 8'd9, 3'd4);
    repeat (4) send(8'd9, 1'b0);
    repeat (2) @(negedge clk);

`ifdef QUAD_GATHER_PAD_EN
    push(8'd3, 8'd5, 8'hFF, 8'hFF, 3'd2);
    send(8'd3, 1'b0);
    send(8'd5, 1'b1);
    check("pad_short_cnt", 32'(grp_cnt), 32'd2);
    @(negedge clk);
    grp_ready = 1'b0;
    push(8'd40, 8'd41, 8'd42, 8'd43, 3'd4);
    send(8'd40, 1'b0);
    send(8'd41, 1'b0);
    send(8'd42, 1'b0);
    send(8'd43, 1'b1);
    push(8'd6, 8'hFF, 8'hFF, 8'hFF, 3'd1);
    send(8'd6, 1'b1);
    check("pad_held_in_ready", 32'(in_ready), 32'd0);
    grp_ready = 1'b1;
    repeat (3) @(negedge clk);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
